// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes,
// datapath mux selects and ALUOp codes used by the ALU control.
package mc_pkg;

  typedef enum logic [4:0] {
    S_IDLE    = 5'd0,
    S_FETCH   = 5'd1,
    S_DECODE  = 5'd2,
    S_RTYPE   = 5'd3,
    S_RWB     = 5'd4,
    S_MEMADR  = 5'd5,
    S_MEMRD   = 5'd6,
    S_MEMWB   = 5'd7,
    S_MEMWR   = 5'd8,
    S_BEQ     = 5'd9,
    S_JUMP    = 5'd10,
    S_JAL     = 5'd11,
    S_JR      = 5'd12,
    S_ADDI_EX = 5'd13,
    S_ADDI_WB = 5'd14,
    S_TRAP    = 5'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // States whose exit completes an instruction (MEMWR only once mem_ready).
  function automatic logic is_retiring(input state_t s);
    case (s)
      S_RWB, S_MEMWB, S_MEMWR, S_BEQ, S_JUMP, S_JAL, S_JR, S_ADDI_WB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_next_state.sv
// DECODE dispatch: combinational map from opcode/funct (and ENABLE_ADDI)
// to the first post-decode state; unrecognised opcodes select S_TRAP.
module mc_next_state
  import mc_pkg::*;
#(
  parameter bit ENABLE_ADDI = 1'b1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_t     next
);

  always_comb begin
    next = S_TRAP;
    case (opcode)
      OP_RTYPE: next = (funct == FN_JR) ? S_JR : S_RTYPE;
      OP_LW,
      OP_SW:    next = S_MEMADR;
      OP_BEQ:   next = S_BEQ;
      OP_J:     next = S_JUMP;
      OP_JAL:   next = S_JAL;
      OP_ADDI:  next = ENABLE_ADDI ? S_ADDI_EX : S_TRAP;
      default:  next = S_TRAP;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle main control: sequences fetch/decode/execute/memory/writeback,
// with a memory wait handshake, sticky illegal trap and retired counter.
module mc_control
  import mc_pkg::*;
#(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit TRAP_HALT   = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output state_t           state
);

  state_t dispatch;

  mc_next_state #(.ENABLE_ADDI(ENABLE_ADDI)) u_next_state (
    .opcode (opcode),
    .funct  (funct),
    .next   (dispatch)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      if (is_retiring(state) && (state != S_MEMWR || mem_ready))
        retired <= retired + CNT_W'(1);
      case (state)
        S_IDLE:    state <= S_FETCH;
        S_FETCH:   if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          state <= dispatch;
          if (dispatch == S_TRAP) illegal <= 1'b1;
        end
        S_RTYPE:   state <= S_RWB;
        S_MEMADR:  state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (mem_ready) state <= S_MEMWB;
        S_MEMWR:   if (mem_ready) state <= S_FETCH;
        S_ADDI_EX: state <= S_ADDI_WB;
        S_TRAP:    state <= TRAP_HALT ? S_TRAP : S_FETCH;
        S_RWB, S_MEMWB, S_BEQ, S_JUMP, S_JAL, S_JR, S_ADDI_WB:
                   state <= S_FETCH;
        default:   state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; only IRWrite/PCWrite in FETCH look at mem_ready.
  always_comb begin
    mem_req     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = PC_ALU;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALU_ADD;
    RegWrite    = 1'b0;
    RegDst      = DST_RT;
    MemtoReg    = M2R_ALUOUT;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH;
      S_RTYPE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = DST_RD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PC_JUMP;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = PC_JUMP;
        RegWrite = 1'b1;
        RegDst   = DST_RA;
        MemtoReg = M2R_PC;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = PC_RS;
      end
      S_ADDI_WB: RegWrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control (CNT_W = 4 so the retired wrap is reachable).
module tb_mc_control;
  import mc_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       opcode, funct;
  logic             mem_ready;
  logic             mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
  logic [1:0]       PCSource, ALUSrcB, ALUOp, RegDst, MemtoReg;
  logic             ALUSrcA, RegWrite, illegal;
  logic [CNT_W-1:0] retired;
  state_t           state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_q[$];

  mc_control #(.ENABLE_ADDI(1'b1), .TRAP_HALT(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .illegal(illegal), .retired(retired), .state(state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  wire [18:0] outs = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond,
                      PCSource, ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst, MemtoReg};
  wire        any_strobe = mem_req | MemRead | MemWrite | IRWrite | PCWrite |
                           PCWriteCond | RegWrite;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic tick_state(input string tag, input state_t exp);
    tick();
    check(tag, 32'(state), 32'(exp));
  endtask

  initial begin
    int req_n, irw_n, pcw_n, strobe_n;

    rst_n = 1'b0; opcode = OP_LW; funct = 6'd0; mem_ready = 1'b0;
    tick(); tick();
    check("reset_state", 32'(state), 32'(S_IDLE));
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);

    // lw with no memory wait: scoreboard of expected states
    rst_n = 1'b1; mem_ready = 1'b1;
    exp_q = {5'(S_FETCH), 5'(S_DECODE), 5'(S_MEMADR), 5'(S_MEMRD), 5'(S_MEMWB), 5'(S_FETCH)};
    while (exp_q.size() > 0) begin
      logic [4:0] e;
      e = exp_q.pop_front();
      tick();
      check("lw_state", 32'(state), 32'(e));
      if (e == 5'(S_FETCH) && exp_q.size() == 5)
        check("lw_fetch_irw", 32'({IRWrite, PCWrite, ALUSrcB}), 32'({1'b1, 1'b1, SRCB_FOUR}));
      if (e == 5'(S_MEMRD))
        check("lw_memrd", 32'({mem_req, MemRead, IorD}), 32'b111);
      if (e == 5'(S_MEMWB)) begin
        check("lw_memwb", 32'({RegWrite, MemtoReg, RegDst}), 32'({1'b1, M2R_MDR, DST_RT}));
        check("lw_ret_before", 32'(retired), 32'd0);
      end
    end
    check("lw_ret_after", 32'(retired), 32'd1);

    // FETCH held 3 cycles by mem_ready low, then R-type add
    opcode = OP_RTYPE; funct = 6'b100000;
    req_n = 0; irw_n = 0; pcw_n = 0;
    mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) mem_ready = 1'b1;
      #1;
      req_n += int'(mem_req); irw_n += int'(IRWrite); pcw_n += int'(PCWrite);
      if (c == 4) check("wait_irw_c4", 32'({IRWrite, PCWrite}), 32'b11);
      if (c < 4) tick();
    end
    check("wait_req_cnt", 32'(req_n), 32'd4);
    check("wait_irw_cnt", 32'(irw_n), 32'd1);
    check("wait_pcw_cnt", 32'(pcw_n), 32'd1);
    tick_state("rt_decode", S_DECODE);
    check("decode_outs", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'({1'b0, SRCB_IMM_SH, ALU_ADD}));
    tick_state("rt_rtype", S_RTYPE);
    check("rt_aluop", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'({1'b1, SRCB_RT, ALU_FUNCT}));
    tick_state("rt_rwb", S_RWB);
    check("rt_rwb_outs", 32'({RegWrite, RegDst, MemtoReg}), 32'({1'b1, DST_RD, M2R_ALUOUT}));
    tick_state("rt_fetch", S_FETCH);
    check("rt_retired", 32'(retired), 32'd2);

    // jr
    funct = FN_JR;
    tick_state("jr_decode", S_DECODE);
    tick_state("jr_state", S_JR);
    check("jr_outs", 32'({PCWrite, PCSource, RegWrite}), 32'({1'b1, PC_RS, 1'b0}));
    tick_state("jr_fetch", S_FETCH);
    check("jr_retired", 32'(retired), 32'd3);

    // jal: exactly one JAL cycle
    opcode = OP_JAL; funct = 6'd0;
    tick_state("jal_decode", S_DECODE);
    tick_state("jal_state", S_JAL);
    check("jal_outs", 32'({PCWrite, PCSource, RegWrite, RegDst, MemtoReg}),
          32'({1'b1, PC_JUMP, 1'b1, DST_RA, M2R_PC}));
    tick_state("jal_fetch", S_FETCH);
    check("jal_retired", 32'(retired), 32'd4);

    // sw stalled in MEMWR, then reset mid-wait
    opcode = OP_SW;
    tick_state("sw_decode", S_DECODE);
    tick_state("sw_memadr", S_MEMADR);
    check("sw_memadr_outs", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'({1'b1, SRCB_IMM, ALU_ADD}));
    mem_ready = 1'b0;
    tick_state("sw_memwr", S_MEMWR);
    check("sw_memwr_outs", 32'({mem_req, MemWrite, IorD, MemRead}), 32'b1110);
    tick_state("sw_memwr_hold", S_MEMWR);
    rst_n = 1'b0;
    tick_state("sw_rst_idle", S_IDLE);
    check("sw_rst_memwrite", 32'(MemWrite), 32'd0);
    check("sw_rst_outs", 32'(outs), 32'd0);
    check("sw_rst_retired", 32'(retired), 32'd4 & 32'd0);

    // 16 beq instructions wrap the 4-bit counter
    rst_n = 1'b1; mem_ready = 1'b1; opcode = OP_BEQ;
    tick_state("beq_fetch0", S_FETCH);
    for (int i = 0; i < 16; i++) begin
      tick();
      tick();
      if (i == 0) begin
        check("beq_state", 32'(state), 32'(S_BEQ));
        check("beq_outs", 32'({ALUSrcA, ALUSrcB, ALUOp, PCWriteCond, PCSource, PCWrite}),
              32'({1'b1, SRCB_RT, ALU_SUB, 1'b1, PC_ALUOUT, 1'b0}));
      end
      tick();
      check("beq_retired", 32'(retired), 32'((i + 1) % 16));
    end

    // addi
    opcode = OP_ADDI;
    tick_state("addi_decode", S_DECODE);
    tick_state("addi_ex", S_ADDI_EX);
    check("addi_ex_outs", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'({1'b1, SRCB_IMM, ALU_ADD}));
    tick_state("addi_wb", S_ADDI_WB);
    check("addi_wb_outs", 32'({RegWrite, RegDst, MemtoReg}), 32'({1'b1, DST_RT, M2R_ALUOUT}));
    tick_state("addi_fetch", S_FETCH);
    check("addi_retired", 32'(retired), 32'd1);

    // illegal opcode traps and halts
    opcode = 6'b111111;
    tick_state("trap_decode", S_DECODE);
    check("trap_pre_illegal", 32'(illegal), 32'd0);
    tick_state("trap_state", S_TRAP);
    check("trap_illegal", 32'(illegal), 32'd1);
    strobe_n = 0;
    for (int i = 0; i < 20; i++) begin
      strobe_n += int'(any_strobe);
      tick();
    end
    check("trap_strobes", 32'(strobe_n), 32'd0);
    check("trap_hold_state", 32'(state), 32'(S_TRAP));
    check("trap_hold_illegal", 32'(illegal), 32'd1);
    check("trap_retired", 32'(retired), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
